// File: rtl/fb_fill_arbiter.sv
// fb_fill_arbiter
// Owns the single framebuffer write port ({Y[5:0], X[6:0]} address, 8-bit color)
// and shares it between MCU single-pixel writes and a rectangle-fill engine.
// An MCU write always wins; the fill engine stalls its cursor for that cycle.
module fb_fill_arbiter #(
  parameter int XMAX = 79,
  parameter int YMAX = 59
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MCU_WE,
  input  logic [12:0] MCU_WA,
  input  logic [7:0]  MCU_WD,
  input  logic        FILL_START,
  input  logic        FILL_ABORT,
  input  logic [6:0]  X0,
  input  logic [6:0]  X1,
  input  logic [5:0]  Y0,
  input  logic [5:0]  Y1,
  input  logic [7:0]  FILL_COLOR,
  output logic [12:0] FB_WA,
  output logic [7:0]  FB_WD,
  output logic        FB_WE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [6:0] X_LIM = 7'(XMAX);
  localparam logic [5:0] Y_LIM = 6'(YMAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t     state;
  logic [6:0] cx, x0_q, x1_q;
  logic [5:0] cy, y0_q, y1_q;
  logic [7:0] color_q;

  logic [6:0] x0_c, x1_c;
  logic [5:0] y0_c, y1_c;
  logic       cmd_bad;

  // Clip the incoming rectangle to the visible area and flag empty rectangles.
  always_comb begin
    x0_c    = (X0 > X_LIM) ? X_LIM : X0;
    x1_c    = (X1 > X_LIM) ? X_LIM : X1;
    y0_c    = (Y0 > Y_LIM) ? Y_LIM : Y0;
    y1_c    = (Y1 > Y_LIM) ? Y_LIM : Y1;
    cmd_bad = (x0_c > x1_c) || (y0_c > y1_c);
  end

  // Port arbitration, command latch and raster cursor; every output is registered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      cx      <= '0;
      cy      <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      FB_WA   <= '0;
      FB_WD   <= '0;
      FB_WE   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below are
      // overridden later in the same block, and the last assignment wins.
      FB_WE <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;

      // MCU writes are served in every state with one cycle of latency.
      if (MCU_WE) begin
        FB_WE <= 1'b1;
        FB_WA <= MCU_WA;
        FB_WD <= MCU_WD;
      end

      case (state)
        S_IDLE: begin
          if (FILL_START) begin
            if (cmd_bad) begin
              ERR <= 1'b1;
            end else begin
              x0_q    <= x0_c;
              x1_q    <= x1_c;
              y0_q    <= y0_c;
              y1_q    <= y1_c;
              color_q <= FILL_COLOR;
              cx      <= x0_c;
              cy      <= y0_c;
              BUSY    <= 1'b1;
              state   <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (FILL_ABORT) begin
            state <= S_DONE;
          end else if (!MCU_WE) begin
            FB_WE <= 1'b1;
            FB_WA <= {cy, cx};
            FB_WD <= color_q;
            if (cx == x1_q) begin
              cx <= x0_q;
              if (cy == y1_q) begin
                state <= S_DONE;
              end else begin
                cy <= cy + 6'd1;
              end
            end else begin
              cx <= cx + 7'd1;
            end
          end
        end

        S_DONE: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Self-checking bench for fb_fill_arbiter: a table of fill commands, hand-written
// multi-cycle sequences, and randomized traffic compared every cycle against a
// pixel-queue reference model.
module tb_fb_fill_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        MCU_WE = 1'b0;
  logic [12:0] MCU_WA = '0;
  logic [7:0]  MCU_WD = '0;
  logic        FILL_START = 1'b0;
  logic        FILL_ABORT = 1'b0;
  logic [6:0]  X0 = '0, X1 = '0;
  logic [5:0]  Y0 = '0, Y1 = '0;
  logic [7:0]  FILL_COLOR = '0;
  logic [12:0] FB_WA;
  logic [7:0]  FB_WD;
  logic        FB_WE, BUSY, DONE, ERR;

  int checks = 0;
  int failures = 0;

  fb_fill_arbiter #(.XMAX(79), .YMAX(59)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .MCU_WE(MCU_WE), .MCU_WA(MCU_WA), .MCU_WD(MCU_WD),
    .FILL_START(FILL_START), .FILL_ABORT(FILL_ABORT),
    .X0(X0), .X1(X1), .Y0(Y0), .Y1(Y1), .FILL_COLOR(FILL_COLOR),
    .FB_WA(FB_WA), .FB_WD(FB_WD), .FB_WE(FB_WE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #10 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending fill pixels ----------
  int  m_pix[$];
  bit  m_busy, m_end;
  int  m_color;
  bit  e_we, e_busy, e_done, e_err;
  int  e_wa, e_wd;

  task automatic model_step();
    int a0, a1, b0, b1;
    e_we = 0; e_done = 0; e_err = 0;
    if (!RESET_N) begin
      m_pix.delete(); m_busy = 0; m_end = 0; e_busy = 0;
      return;
    end
    if (MCU_WE) begin
      e_we = 1; e_wa = int'(MCU_WA); e_wd = int'(MCU_WD);
    end
    if (!m_busy) begin
      if (FILL_START) begin
        a0 = (int'(X0) > 79) ? 79 : int'(X0);
        a1 = (int'(X1) > 79) ? 79 : int'(X1);
        b0 = (int'(Y0) > 59) ? 59 : int'(Y0);
        b1 = (int'(Y1) > 59) ? 59 : int'(Y1);
        if (a0 > a1 || b0 > b1) begin
          e_err = 1;
        end else begin
          m_pix.delete();
          for (int y = b0; y <= b1; y++)
            for (int x = a0; x <= a1; x++)
              m_pix.push_back(y * 128 + x);
          m_color = int'(FILL_COLOR);
          m_busy  = 1;
        end
      end
    end else if (m_end) begin
      e_done = 1; m_busy = 0; m_end = 0;
    end else if (FILL_ABORT) begin
      m_end = 1;
    end else if (!MCU_WE) begin
      e_we = 1; e_wa = m_pix.pop_front(); e_wd = m_color;
      if (m_pix.size() == 0) m_end = 1;
    end
    e_busy = m_busy;
  endtask

  // ---------------- observation log ----------------------------------------
  int obs_a[$], obs_d[$];
  int done_cnt, err_cnt;
  bit busy_at_done;

  task automatic clear_obs();
    obs_a.delete(); obs_d.delete(); done_cnt = 0; err_cnt = 0; busy_at_done = 0;
  endtask

  // One clock: inputs set beforehand; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check("fb_we", int'(FB_WE), int'(e_we));
    check("busy", int'(BUSY), int'(e_busy));
    check("done", int'(DONE), int'(e_done));
    check("err", int'(ERR), int'(e_err));
    if (e_we) begin
      check("fb_wa", int'(FB_WA), e_wa);
      check("fb_wd", int'(FB_WD), e_wd);
    end
    if (FB_WE) begin obs_a.push_back(int'(FB_WA)); obs_d.push_back(int'(FB_WD)); end
    if (DONE) begin done_cnt++; busy_at_done = BUSY; end
    if (ERR) err_cnt++;
    @(negedge CLK);
    MCU_WE = 0; FILL_START = 0;
  endtask

  task automatic start_fill(input int x0, input int x1, input int y0, input int y1,
                            input int col);
    X0 = 7'(x0); X1 = 7'(x1); Y0 = 6'(y0); Y1 = 6'(y1); FILL_COLOR = 8'(col);
    FILL_START = 1;
  endtask

  task automatic run_to_end(input int budget);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < budget) begin cycle(); n++; end
    check("end_reached", int'((done_cnt + err_cnt) > 0), 1);
  endtask

  // ---------------- command table ------------------------------------------
  typedef struct {
    int x0, x1, y0, y1, col;
    int err, nwr, first, last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_a[7];
    int exp_d[7];

    vecs[0] = '{x0: 2,   x1: 4,   y0: 1,  y1: 2,  col: 'h1C, err: 0, nwr: 6,  first: 'h082,  last: 'h104};
    vecs[1] = '{x0: 5,   x1: 3,   y0: 0,  y1: 0,  col: 'h11, err: 1, nwr: 0,  first: 0,      last: 0};
    vecs[2] = '{x0: 70,  x1: 127, y0: 59, y1: 59, col: 'h22, err: 0, nwr: 10, first: 'h1DC6, last: 'h1DCF};
    vecs[3] = '{x0: 0,   x1: 0,   y0: 0,  y1: 0,  col: 'h33, err: 0, nwr: 1,  first: 'h000,  last: 'h000};
    vecs[4] = '{x0: 127, x1: 127, y0: 63, y1: 63, col: 'h44, err: 0, nwr: 1,  first: 'h1DCF, last: 'h1DCF};
    vecs[5] = '{x0: 0,   x1: 3,   y0: 10, y1: 5,  col: 'h55, err: 1, nwr: 0,  first: 0,      last: 0};
    vecs[6] = '{x0: 100, x1: 90,  y0: 0,  y1: 0,  col: 'h66, err: 0, nwr: 1,  first: 'h04F,  last: 'h04F};
    vecs[7] = '{x0: 10,  x1: 12,  y0: 60, y1: 63, col: 'h77, err: 0, nwr: 3,  first: 'h1D8A, last: 'h1D8C};

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_fb_we", int'(FB_WE), 0);
    check("rst_fb_wa", int'(FB_WA), 0);
    check("rst_fb_wd", int'(FB_WD), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_err", int'(ERR), 0);
    RESET_N = 1;
    cycle();

    // MCU write latency.
    MCU_WE = 1; MCU_WA = 13'h0A05; MCU_WD = 8'hE0;
    cycle();
    check("mcu_we", int'(FB_WE), 1);
    check("mcu_wa", int'(FB_WA), 'h0A05);
    check("mcu_wd", int'(FB_WD), 'hE0);
    cycle();
    check("mcu_we_off", int'(FB_WE), 0);

    // Table of fill commands.
    foreach (vecs[i]) begin
      clear_obs();
      start_fill(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].col);
      cycle();
      run_to_end(200);
      cycle();
      check($sformatf("v%0d_err", i), err_cnt, vecs[i].err);
      check($sformatf("v%0d_done", i), done_cnt, 1 - vecs[i].err);
      check($sformatf("v%0d_nwr", i), obs_a.size(), vecs[i].nwr);
      if (vecs[i].nwr > 0 && obs_a.size() > 0) begin
        check($sformatf("v%0d_first", i), obs_a[0], vecs[i].first);
        check($sformatf("v%0d_last", i), obs_a[obs_a.size() - 1], vecs[i].last);
        check($sformatf("v%0d_color", i), obs_d[0], vecs[i].col);
        check($sformatf("v%0d_busy_at_done", i), int'(busy_at_done), 0);
      end
    end

    // Fill 2..4 x 1..2 with an MCU write stalling the third fill write.
    clear_obs();
    start_fill(2, 4, 1, 2, 'h1C);
    cycle();
    cycle();
    cycle();
    MCU_WE = 1; MCU_WA = 13'h0123; MCU_WD = 8'h55;
    cycle();
    run_to_end(50);
    cycle();
    exp_a = '{130, 131, 291, 132, 258, 259, 260};
    exp_d = '{'h1C, 'h1C, 'h55, 'h1C, 'h1C, 'h1C, 'h1C};
    check("stall_nwr", obs_a.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < obs_a.size()) begin
        check($sformatf("stall_a%0d", i), obs_a[i], exp_a[i]);
        check($sformatf("stall_d%0d", i), obs_d[i], exp_d[i]);
      end
    end

    // FILL_START together with MCU_WE, and FILL_ABORT ignored in IDLE.
    clear_obs();
    start_fill(7, 7, 3, 3, 'hA5);
    FILL_ABORT = 1;
    MCU_WE = 1; MCU_WA = 13'h0042; MCU_WD = 8'h99;
    cycle();
    FILL_ABORT = 0;
    run_to_end(20);
    cycle();
    check("same_nwr", obs_a.size(), 2);
    if (obs_a.size() == 2) begin
      check("same_first", obs_a[0], 'h0042);
      check("same_fill", obs_a[1], 3 * 128 + 7);
    end

    // Full-screen fill, ignored second start, abort after 100 writes.
    begin
      int n = 0;
      clear_obs();
      start_fill(0, 79, 0, 59, 'hF0);
      cycle();
      while (obs_a.size() < 100 && n < 300) begin
        if (n == 50) start_fill(0, 0, 0, 0, 'h0F);
        cycle();
        n++;
      end
      FILL_ABORT = 1;
      cycle();
      FILL_ABORT = 0;
      run_to_end(10);
      cycle();
      check("abort_nwr", obs_a.size(), 100);
      check("abort_done", done_cnt, 1);
      check("abort_err", err_cnt, 0);
      if (obs_a.size() == 100) begin
        check("abort_a60", obs_a[60], 60);
        check("abort_a99", obs_a[99], 128 + 19);
        check("abort_d99", obs_d[99], 'hF0);
      end
    end

    // Reset asserted mid-fill.
    clear_obs();
    start_fill(0, 79, 0, 3, 'h12);
    cycle();
    repeat (20) cycle();
    #5;
    RESET_N = 0;
    #1;
    check("mid_rst_fb_we", int'(FB_WE), 0);
    check("mid_rst_fb_wa", int'(FB_WA), 0);
    check("mid_rst_fb_wd", int'(FB_WD), 0);
    check("mid_rst_busy", int'(BUSY), 0);
    check("mid_rst_done", int'(DONE), 0);
    check("mid_rst_err", int'(ERR), 0);
    @(negedge CLK);
    repeat (2) cycle();
    RESET_N = 1;
    repeat (3) cycle();
    check("mid_rst_no_done", done_cnt, 0);
    clear_obs();
    start_fill(0, 0, 0, 0, 'h3F);
    cycle();
    run_to_end(10);
    cycle();
    check("post_rst_nwr", obs_a.size(), 1);
    if (obs_a.size() == 1) begin
      check("post_rst_wa", obs_a[0], 0);
      check("post_rst_wd", obs_d[0], 'h3F);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      MCU_WE = ($urandom_range(0, 3) == 0);
      MCU_WA = 13'($urandom);
      MCU_WD = 8'($urandom);
      FILL_ABORT = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) == 0) begin
        X0 = 7'($urandom_range(0, 127));
        X1 = 7'(int'(X0) + $urandom_range(0, 6));
        Y0 = 6'($urandom_range(0, 63));
        Y1 = 6'(int'(Y0) + $urandom_range(0, 3));
        FILL_COLOR = 8'($urandom);
        FILL_START = 1;
      end
      cycle();
    end
    FILL_ABORT = 0;
    repeat (40) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_fill_arbiter.md
Name: fb_fill_arbiter

Overview:
- Owns the single write port of the VGA framebuffer (13-bit address = {Y[5:0], X[6:0]}, 8-bit color).
- Shares that port between two requesters:
  - MCU single-pixel writes from the output-port decode (HADDR/LADDR/COLOR path).
  - A hardware rectangle-fill engine, started by one command.
- Sits between the wrapper's port-decode registers and vga_fb_driver WA/WD/WE, and runs in the 50 MHz MCU clock domain.

Parameters:
- XMAX, 79, last visible column; fill X coordinates are clipped to this value.
- YMAX, 59, last visible row; fill Y coordinates are clipped to this value.

Ports:
- CLK  in  1  clock; the MCU clock (s_clk_50).
- RESET_N  in  1  asynchronous, active-low reset.
- MCU_WE  in  1  one-cycle pulse: write MCU_WD to MCU_WA.
- MCU_WA  in  13  MCU pixel address {Y,X}.
- MCU_WD  in  8  MCU pixel color.
- FILL_START  in  1  one-cycle pulse: latch the rectangle command.
- FILL_ABORT  in  1  level; terminates an active fill.
- X0, X1  in  7  rectangle column bounds, inclusive.
- Y0, Y1  in  6  rectangle row bounds, inclusive.
- FILL_COLOR  in  8  fill color.
- FB_WA  out  13  framebuffer write address.
- FB_WD  out  8  framebuffer write data.
- FB_WE  out  1  framebuffer write enable.
- BUSY  out  1  high while the fill engine is not IDLE.
- DONE  out  1  one-cycle pulse when a fill ends (completed or aborted).
- ERR  out  1  one-cycle pulse when a fill command is rejected.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - FB_WA=0, FB_WD=0, FB_WE=0, BUSY=0, DONE=0, ERR=0.
  - State=IDLE; cursor and latched command registers cleared.
  - Reset asserted mid-fill ends the fill immediately, with no DONE pulse.
- All outputs are registered.
- MCU write latency: FB_WE is high exactly 1 cycle after MCU_WE is sampled, with FB_WA=MCU_WA and FB_WD=MCU_WD.
- Priority: an MCU write always wins.
  - In a cycle where MCU_WE=1, the fill engine issues no write and holds its cursor (stall).
  - MCU writes are never dropped or delayed, and are served in every state.
- Command latch (FILL_START in IDLE):
  - X0/X1 are clipped independently to min(v, XMAX); Y0/Y1 are clipped to min(v, YMAX).
  - If clipped X0 > clipped X1, or Y0 > Y1: ERR pulses the next cycle, state stays IDLE, no writes.
  - Otherwise: store the bounds and color, set cursor cx=X0, cy=Y0, go to FILL. BUSY=1 from the next cycle.
  - FILL_START while BUSY=1 is ignored: no ERR, and the current fill is unaffected.
- States:
  - IDLE: wait for FILL_START.
  - FILL: in each cycle without MCU_WE, write {cy,cx} with the latched color.
    - Raster order: cx increments. If cx==X1, cx returns to X0 and cy increments.
    - The write at (X1,Y1) is the last write; the next state is DONE.
  - DONE: DONE=1 for one cycle, BUSY drops in the same cycle, then IDLE.
- Write count: exactly (X1-X0+1)*(Y1-Y0+1) fill writes per completed command.
  - A 1x1 rectangle produces 1 write.
  - A full-screen fill (0..79, 0..59) produces 4800 writes.
- Arithmetic:
  - Cursor compares are on the clipped values; cx is 7 bits and cy is 6 bits.
  - No wrap beyond XMAX/YMAX, because the bounds are already clipped.
- FILL_ABORT sampled high in FILL:
  - No further fill writes; go to DONE.
  - An MCU write in the same cycle is still served.
- FILL_START and FILL_ABORT in the same cycle in IDLE: FILL_ABORT has no effect; the command is accepted.
- FILL_START and MCU_WE in the same cycle: both are accepted; the MCU write is issued first, and the fill starts writing once no MCU_WE is present.

Test Plan:
- Reset, then MCU_WE pulse with WA=13'h0A05, WD=8'hE0 -> one cycle later FB_WE=1, FB_WA=13'h0A05, FB_WD=8'hE0; FB_WE=0 the following cycle.
- FILL X0=2, X1=4, Y0=1, Y1=2, color 8'h1C -> exactly 6 writes in order (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), on consecutive cycles; then DONE pulse and BUSY falls.
- During that fill, MCU_WE pulse on the cycle before the 3rd write -> the MCU write appears on FB; fill writes resume without skipping or duplicating any pixel; 6 fill writes total.
- FILL X0=5, X1=3 -> ERR pulse, zero FB_WE, BUSY stays 0. FILL X0=70, X1=127, Y0=Y1=59 -> X1 clipped to 79, 10 writes.
- Full-screen fill, FILL_ABORT raised after 100 writes -> no more fill writes, one DONE pulse. Second FILL_START issued while BUSY -> ignored.
- RESET_N dropped mid-fill -> all outputs 0 asynchronously, no DONE; after release, a new 1x1 fill at (0,0) -> 1 write to address 0.
